set_associative_cache: RTL and testbench

Parametrised N-way set-associative, byte-addressable, write-back, write-allocate cache with true-LRU replacement. It sits between a requesting device and external word-wide RAM, and uses the same device-side and RAM-side port protocol as the direct-mapped cache. It replaces that cache where conflict misses matter. Line fill and write-back are word-serial bursts over the RAM handshake.

---
 rtl/set_associative_cache.sv | 220 ++++++++++++++++++++++
 tb/tb_set_associative_cache.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/set_associative_cache.sv
// N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
// Line fill and write-back are word-serial bursts over a ready-handshaked word-wide RAM port.
module set_associative_cache #(
    parameter int unsigned ADDRESS_WIDTH     = 16,
    parameter int unsigned SET_INDEX_WIDTH   = 3,
    parameter int unsigned WORD_OFFSET_WIDTH = 2,
    parameter int unsigned WAYS              = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] cache_address,
    input  logic                     cache_rd,
    input  logic                     cache_wr,
    input  logic [3:0]               cache_byte_enable,
    input  logic [31:0]              cache_data_wr,
    output logic [31:0]              cache_data_out,
    output logic                     cache_ready,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [3:0]               ram_byte_enable,
    output logic [31:0]              ram_data_wr,
    input  logic [31:0]              ram_data_rd,
    input  logic                     ram_ready
);
    localparam int TAG_WIDTH_CHK = int'(ADDRESS_WIDTH) - int'(SET_INDEX_WIDTH)
                                 - int'(WORD_OFFSET_WIDTH) - 2;
    localparam int unsigned TAG_WIDTH = (TAG_WIDTH_CHK < 1) ? 1 : unsigned'(TAG_WIDTH_CHK);
    localparam int unsigned SETS      = 1 << SET_INDEX_WIDTH;
    localparam int unsigned WORDS     = 1 << WORD_OFFSET_WIDTH;
    localparam int unsigned WAY_W     = $clog2(WAYS);
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] WRITEBACK = 3'd2;
    localparam logic [2:0] FILL      = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
        $fatal(1, "set_associative_cache: WAYS must be a power of 2 and at least 2");
    end
    if (TAG_WIDTH_CHK < 1) begin : g_bad_tag
        $fatal(1, "set_associative_cache: address too narrow for a tag");
    end

    logic [31:0]          data_mem [WAYS][SETS][WORDS];
    logic [TAG_WIDTH-1:0] tag_mem  [SETS][WAYS];
    logic [WAYS-1:0]      valid_q  [SETS];
    logic [WAYS-1:0]      dirty_q  [SETS];
    logic [WAY_W-1:0]     age_q    [SETS][WAYS];

    logic [2:0]                   state_q, state_d;
    logic [WORD_OFFSET_WIDTH-1:0] word_q, word_d;
    logic [ADDRESS_WIDTH-1:0]     req_addr;
    logic                         req_wr;
    logic [3:0]                   req_be;
    logic [31:0]                  req_data;
    logic [WAY_W-1:0]             victim_q;

    logic [TAG_WIDTH-1:0]         req_tag;
    logic [SET_INDEX_WIDTH-1:0]   req_set;
    logic [WORD_OFFSET_WIDTH-1:0] req_word;
    logic                         unused_byte_offset;

    assign req_tag            = req_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign req_set            = req_addr[2+WORD_OFFSET_WIDTH +: SET_INDEX_WIDTH];
    assign req_word           = req_addr[2 +: WORD_OFFSET_WIDTH];
    assign unused_byte_offset = ^req_addr[1:0];

    logic                     hit, victim_dirty, last_word;
    logic [WAY_W-1:0]         hit_way, victim_c, way_sel;
    logic [WAYS-1:0]          set_valid, set_dirty;
    logic                     ready_d, ram_rd_d, ram_wr_d;
    logic [ADDRESS_WIDTH-1:0] ram_address_d;
    logic [3:0]               ram_be_d;
    logic [31:0]              ram_data_wr_d;

    assign set_valid = valid_q[req_set];
    assign set_dirty = dirty_q[req_set];
    assign last_word = &word_q;

    // Tag match and victim choice: oldest way, overridden by the lowest-index invalid way.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        victim_c = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (set_valid[WAY_W'(w)] && tag_mem[req_set][WAY_W'(w)] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (age_q[req_set][WAY_W'(w)] == OLDEST) victim_c = WAY_W'(w);
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!set_valid[WAY_W'(w)]) victim_c = WAY_W'(w);
        end
        victim_dirty = set_valid[victim_c] & set_dirty[victim_c];
        way_sel      = (state_q == LOOKUP) ? victim_c : victim_q;
    end

    // Next state plus the next values of the registered RAM-side outputs.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        ready_d       = 1'b0;
        ram_address_d = '0;
        ram_be_d      = 4'h0;
        ram_data_wr_d = 32'h0;
        case (state_q)
            IDLE:      if (cache_rd || cache_wr) state_d = LOOKUP;
            LOOKUP: begin
                word_d = '0;
                if (hit) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    state_d = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: if (ram_ready) begin
                word_d = word_q + 1'b1;
                if (last_word) state_d = FILL;
            end
            FILL:      if (ram_ready) begin
                word_d = word_q + 1'b1;
                if (last_word) state_d = LOOKUP;
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        ram_rd_d = (state_d == FILL);
        ram_wr_d = (state_d == WRITEBACK);
        if (state_d == WRITEBACK) begin
            ram_address_d = {tag_mem[req_set][way_sel], req_set, word_d, 2'b00};
            ram_be_d      = 4'hF;
            ram_data_wr_d = data_mem[way_sel][req_set][word_d];
        end else if (state_d == FILL) begin
            ram_address_d = {req_tag, req_set, word_d, 2'b00};
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            word_q          <= '0;
            req_addr        <= '0;
            req_wr          <= 1'b0;
            req_be          <= 4'h0;
            req_data        <= 32'h0;
            victim_q        <= '0;
            cache_data_out  <= 32'h0;
            cache_ready     <= 1'b0;
            ram_address     <= '0;
            ram_rd          <= 1'b0;
            ram_wr          <= 1'b0;
            ram_byte_enable <= 4'h0;
            ram_data_wr     <= 32'h0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            cache_ready     <= ready_d;
            ram_address     <= ram_address_d;
            ram_rd          <= ram_rd_d;
            ram_wr          <= ram_wr_d;
            ram_byte_enable <= ram_be_d;
            ram_data_wr     <= ram_data_wr_d;
            if (state_q == IDLE && (cache_rd || cache_wr)) begin
                req_addr <= cache_address;
                req_wr   <= cache_wr;
                req_be   <= cache_byte_enable;
                req_data <= cache_data_wr;
            end
            if (state_q == LOOKUP && !hit) victim_q <= victim_c;
            if (state_q == LOOKUP && hit && !req_wr)
                cache_data_out <= data_mem[hit_way][req_set][req_word];
        end
    end

    // Line status: valid, dirty and per-set LRU ages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[SET_INDEX_WIDTH'(s)] <= '0;
                dirty_q[SET_INDEX_WIDTH'(s)] <= '0;
                for (int w = 0; w < int'(WAYS); w++)
                    age_q[SET_INDEX_WIDTH'(s)][WAY_W'(w)] <= WAY_W'(w);
            end
        end else begin
            if (state_q == LOOKUP && hit) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (age_q[req_set][WAY_W'(w)] < age_q[req_set][hit_way])
                        age_q[req_set][WAY_W'(w)] <= age_q[req_set][WAY_W'(w)] + 1'b1;
                end
                age_q[req_set][hit_way] <= '0;
                if (req_wr) dirty_q[req_set][hit_way] <= 1'b1;
            end
            if (state_q == WRITEBACK && ram_ready && last_word)
                dirty_q[req_set][victim_q] <= 1'b0;
            if (state_q == FILL && ram_ready && last_word) begin
                valid_q[req_set][victim_q] <= 1'b1;
                dirty_q[req_set][victim_q] <= 1'b0;
            end
        end
    end

    // Line data and tags need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && hit && req_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) data_mem[hit_way][req_set][req_word][8*b +: 8] <= req_data[8*b +: 8];
            end
        end
        if (state_q == FILL && ram_ready) begin
            data_mem[victim_q][req_set][word_q] <= ram_data_rd;
            if (last_word) tag_mem[req_set][victim_q] <= req_tag;
        end
    end
endmodule

// File: tb/tb_set_associative_cache.sv
// Directed bench for set_associative_cache: a vector table of requests with expected latency,
// read data and RAM traffic, plus hand sequences for a RAM stall and a reset mid-burst.
module tb_set_associative_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cache_address;
    logic        cache_rd, cache_wr;
    logic [3:0]  cache_byte_enable;
    logic [31:0] cache_data_wr, cache_data_out;
    logic        cache_ready;
    logic [15:0] ram_address;
    logic        ram_rd, ram_wr;
    logic [3:0]  ram_byte_enable;
    logic [31:0] ram_data_wr, ram_data_rd;
    logic        ram_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    set_associative_cache dut (
        .clk(clk), .rst(rst),
        .cache_address(cache_address), .cache_rd(cache_rd), .cache_wr(cache_wr),
        .cache_byte_enable(cache_byte_enable), .cache_data_wr(cache_data_wr),
        .cache_data_out(cache_data_out), .cache_ready(cache_ready),
        .ram_address(ram_address), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_byte_enable(ram_byte_enable), .ram_data_wr(ram_data_wr),
        .ram_data_rd(ram_data_rd), .ram_ready(ram_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM model: written words persist, untouched words are {addr, ~addr}.
    logic [31:0] ram_mem [logic [15:0]];
    function automatic logic [31:0] ram_word(input logic [15:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        if (a == 16'h0044) return 32'h11223344;
        return {a, ~a};
    endfunction

    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];

    // ram_ready only changes just after a rising edge, so here it equals the value sampled next.
    always @(negedge clk) begin
        if (!rst && ram_ready && ram_wr) begin
            wr_log.push_back(ram_address);
            ram_mem[ram_address] = ram_data_wr;
            check("wr_byte_enable", 32'(ram_byte_enable), 32'hF);
        end
        if (!rst && ram_ready && ram_rd) begin
            rd_log.push_back(ram_address);
            check("rd_byte_enable", 32'(ram_byte_enable), 32'h0);
        end
        ram_data_rd = ram_word(ram_address);
    end

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] data;
        int          lat;
        logic [31:0] dout;
        int          nrd;
        int          nwr;
        logic [15:0] wb_base;
    } vec_t;

    vec_t vecs[13];

    // Issue one request just after a rising edge (cycle 0) and return the cache_ready cycle.
    task automatic do_req(input logic [15:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] d, output int lat);
        cache_address     = a;
        cache_wr          = w;
        cache_rd          = !w;
        cache_byte_enable = be;
        cache_data_wr     = d;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (cache_ready) begin
                lat = c;
                break;
            end
        end
        cache_rd = 1'b0;
        cache_wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [15:0] base;

        vecs[0]  = '{16'h0040, 1'b0, 4'h0, 32'h0,        7,  32'h0040FFBF, 4, 0, 16'h0};
        vecs[1]  = '{16'h0048, 1'b0, 4'h0, 32'h0,        2,  32'h0048FFB7, 0, 0, 16'h0};
        vecs[2]  = '{16'h0044, 1'b1, 4'h2, 32'hAABBCCDD, 2,  32'h0048FFB7, 0, 0, 16'h0};
        vecs[3]  = '{16'h0044, 1'b0, 4'h0, 32'h0,        2,  32'h1122CC44, 0, 0, 16'h0};
        vecs[4]  = '{16'h0000, 1'b0, 4'h0, 32'h0,        7,  32'h0000FFFF, 4, 0, 16'h0};
        vecs[5]  = '{16'h0080, 1'b1, 4'hF, 32'hDEADBEEF, 7,  32'h0000FFFF, 4, 0, 16'h0};
        vecs[6]  = '{16'h0100, 1'b0, 4'h0, 32'h0,        7,  32'h0100FEFF, 4, 0, 16'h0};
        vecs[7]  = '{16'h0180, 1'b0, 4'h0, 32'h0,        7,  32'h0180FE7F, 4, 0, 16'h0};
        vecs[8]  = '{16'h0000, 1'b0, 4'h0, 32'h0,        2,  32'h0000FFFF, 0, 0, 16'h0};
        vecs[9]  = '{16'h0200, 1'b0, 4'h0, 32'h0,        11, 32'h0200FDFF, 4, 4, 16'h0080};
        vecs[10] = '{16'h0000, 1'b0, 4'h0, 32'h0,        2,  32'h0000FFFF, 0, 0, 16'h0};
        vecs[11] = '{16'h0084, 1'b0, 4'h0, 32'h0,        7,  32'h0084FF7B, 4, 0, 16'h0};
        vecs[12] = '{16'h0080, 1'b0, 4'h0, 32'h0,        2,  32'hDEADBEEF, 0, 0, 16'h0};

        rst = 1'b1;
        ram_ready = 1'b1;
        cache_address = 16'h0;
        cache_rd = 1'b0;
        cache_wr = 1'b0;
        cache_byte_enable = 4'h0;
        cache_data_wr = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_data_out", cache_data_out, 32'h0);
        check("rst_ready", 32'(cache_ready), 32'h0);
        check("rst_ram_rd", 32'(ram_rd), 32'h0);
        check("rst_ram_wr", 32'(ram_wr), 32'h0);
        check("rst_ram_address", 32'(ram_address), 32'h0);
        check("rst_ram_be", 32'(ram_byte_enable), 32'h0);
        check("rst_ram_data_wr", ram_data_wr, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            rd_log.delete();
            wr_log.delete();
            do_req(vecs[i].addr, vecs[i].wr, vecs[i].be, vecs[i].data, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_data_out", i), cache_data_out, vecs[i].dout);
            check($sformatf("v%0d_rd_count", i), 32'(rd_log.size()), 32'(vecs[i].nrd));
            check($sformatf("v%0d_wr_count", i), 32'(wr_log.size()), 32'(vecs[i].nwr));
            base = {vecs[i].addr[15:4], 4'h0};
            for (int k = 0; k < rd_log.size() && k < vecs[i].nrd; k++)
                check($sformatf("v%0d_rd_addr%0d", i, k), 32'(rd_log[k]), 32'(base + 16'(4 * k)));
            for (int k = 0; k < wr_log.size() && k < vecs[i].nwr; k++)
                check($sformatf("v%0d_wr_addr%0d", i, k), 32'(wr_log[k]),
                      32'(vecs[i].wb_base + 16'(4 * k)));
        end

        // RAM stall: ram_ready low during cycles 3..5 holds FILL word 1 for three extra cycles.
        rd_log.delete();
        cache_address = 16'h00C0;
        cache_rd = 1'b1;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            ram_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                check($sformatf("stall_ram_rd_c%0d", c), 32'(ram_rd), 32'h1);
                check($sformatf("stall_ram_addr_c%0d", c), 32'(ram_address), 32'h00C4);
            end
            if (cache_ready) begin
                lat = c;
                break;
            end
        end
        cache_rd = 1'b0;
        ram_ready = 1'b1;
        check("stall_latency", 32'(lat), 32'd10);
        check("stall_data_out", cache_data_out, 32'h00C0FF3F);
        check("stall_rd_count", 32'(rd_log.size()), 32'd4);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_one_cycle", 32'(cache_ready), 32'h0);
        @(posedge clk);
        #1;

        // Reset in the second FILL cycle drops the strobe at once; the line must refill fully.
        cache_address = 16'h0140;
        cache_rd = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_burst_started", 32'(ram_rd), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ram_rd", 32'(ram_rd), 32'h0);
        check("rst_mid_ram_address", 32'(ram_address), 32'h0);
        cache_rd = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        rd_log.delete();
        wr_log.delete();
        do_req(16'h0140, 1'b0, 4'h0, 32'h0, lat);
        check("refill_latency", 32'(lat), 32'd7);
        check("refill_data_out", cache_data_out, 32'h0140FEBF);
        check("refill_rd_count", 32'(rd_log.size()), 32'd4);
        check("refill_wr_count", 32'(wr_log.size()), 32'd0);
        for (int k = 0; k < rd_log.size() && k < 4; k++)
            check($sformatf("refill_rd_addr%0d", k), 32'(rd_log[k]), 32'(16'h0140 + 16'(4 * k)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
